// File: rtl/misr_bist_ctrl_pkg.sv
// Shared types and default constants for the MISR BIST sequencer.
// The state enum and the default LFSR seed/taps live here so every file agrees on them.
package misr_bist_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StClear = 3'd1,
        StRun   = 3'd2,
        StFlush = 3'd3,
        StCheck = 3'd4,
        StDone  = 3'd5
    } bist_state_e;

    localparam int unsigned DefWidth    = 4;
    localparam int unsigned DefCntW     = 8;
    localparam int unsigned DefFlushCyc = 2;

    // x^4 + x^3 + 1
    localparam logic [3:0] DefTaps = 4'b1100;
    localparam logic [3:0] DefSeed = 4'b1001;

endpackage

// File: rtl/misr_bist_ctrl_lfsr.sv
// Fibonacci LFSR pattern source for the BIST sequencer.
// Shifts left, feeding the XOR of the tapped bits into bit 0; an all-zero seed is replaced by 1.
module misr_bist_ctrl_lfsr
    import misr_bist_ctrl_pkg::*;
#(
    parameter int unsigned      Width = DefWidth,
    parameter logic [Width-1:0] Taps  = Width'(DefTaps),
    parameter logic [Width-1:0] Seed  = Width'(DefSeed)
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             load_i,
    input  logic             adv_i,
    output logic [Width-1:0] state_o
);

    // Zero is the LFSR lock-up state, so it can never be used as a seed.
    localparam logic [Width-1:0] SeedFix = (Seed == '0) ? Width'(1) : Seed;

    logic [Width-1:0] state_q;
    logic [Width-1:0] state_d;

    always_comb begin
        state_d = state_q;
        if (load_i) begin
            state_d = SeedFix;
        end else if (adv_i) begin
            state_d = {state_q[Width-2:0], ^(state_q & Taps)};
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= SeedFix;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/misr_bist_ctrl.sv
// BIST sequencer: clears the MISR, drives N LFSR patterns into the CUT, drains the MISR
// buffer stage and compares the final signature against a golden value.
module misr_bist_ctrl
    import misr_bist_ctrl_pkg::*;
#(
    parameter int unsigned      Width    = DefWidth,
    parameter int unsigned      CntW     = DefCntW,
    parameter logic [Width-1:0] Taps     = Width'(DefTaps),
    parameter logic [Width-1:0] Seed     = Width'(DefSeed),
    parameter int unsigned      FlushCyc = DefFlushCyc
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             start_i,
    input  logic [CntW-1:0]  num_patterns_i,
    input  logic [Width-1:0] golden_sig_i,
    input  logic [Width-1:0] misr_sig_i,
    output logic [Width-1:0] pattern_o,
    output logic             pattern_valid_o,
    output logic             misr_rstn_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             pass_o
);

    localparam int unsigned       FlushW    = (FlushCyc > 2) ? $clog2(FlushCyc) : 1;
    localparam logic [FlushW-1:0] FlushLoad = FlushW'((FlushCyc > 0) ? FlushCyc - 1 : 0);

    bist_state_e       state_q;
    logic [CntW-1:0]   cnt_q;
    logic [FlushW-1:0] flush_q;
    logic [Width-1:0]  pattern_q;
    logic              pattern_valid_q;
    logic              misr_rstn_q;
    logic              busy_q;
    logic              done_q;
    logic              pass_q;

    logic [Width-1:0]  lfsr_state;
    logic              start_ok;
    logic              emit;

    // start is only honoured when no run is in progress.
    assign start_ok = start_i && ((state_q == StIdle) || (state_q == StDone));

    // One pattern leaves per cycle while patterns remain, starting on the CLEAR cycle's edge.
    assign emit = ((state_q == StClear) || (state_q == StRun)) && (cnt_q != '0);

    misr_bist_ctrl_lfsr #(
        .Width (Width),
        .Taps  (Taps),
        .Seed  (Seed)
    ) u_lfsr (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .load_i  (start_ok),
        .adv_i   (emit),
        .state_o (lfsr_state)
    );

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q         <= StIdle;
            cnt_q           <= '0;
            flush_q         <= '0;
            pattern_q       <= '0;
            pattern_valid_q <= 1'b0;
            misr_rstn_q     <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            pass_q          <= 1'b0;
        end else begin
            // MISR clear is a single-cycle pulse; it releases on the first edge out of reset.
            misr_rstn_q <= 1'b1;
            unique case (state_q)
                StIdle, StDone: begin
                    if (start_ok) begin
                        state_q     <= StClear;
                        cnt_q       <= num_patterns_i;
                        misr_rstn_q <= 1'b0;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        pass_q      <= 1'b0;
                    end
                end
                StClear, StRun: begin
                    if (emit) begin
                        state_q         <= StRun;
                        pattern_q       <= lfsr_state;
                        pattern_valid_q <= 1'b1;
                        cnt_q           <= cnt_q - CntW'(1);
                    end else if (state_q == StClear) begin
                        state_q <= StCheck;
                    end else begin
                        pattern_q       <= '0;
                        pattern_valid_q <= 1'b0;
                        if (FlushCyc == 0) begin
                            state_q <= StCheck;
                        end else begin
                            state_q <= StFlush;
                            flush_q <= FlushLoad;
                        end
                    end
                end
                StFlush: begin
                    if (flush_q == '0) begin
                        state_q <= StCheck;
                    end else begin
                        flush_q <= flush_q - FlushW'(1);
                    end
                end
                StCheck: begin
                    state_q <= StDone;
                    pass_q  <= (misr_sig_i == golden_sig_i);
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign pattern_o       = pattern_q;
    assign pattern_valid_o = pattern_valid_q;
    assign misr_rstn_o     = misr_rstn_q;
    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign pass_o          = pass_q;

endmodule

// File: tb/tb_misr_bist_ctrl.sv
// Directed bench for misr_bist_ctrl driving a behavioural 4-bit MISR with a one-stage input
// buffer. Golden signatures are hand-computed for that MISR (4-pattern run -> 4'h4).
module tb_misr_bist_ctrl;

    logic       clk = 1'b0;
    logic       rstn;
    logic       start;
    logic [7:0] num;
    logic [3:0] golden;
    logic [3:0] misr_sig;
    logic [3:0] pattern;
    logic       valid;
    logic       misr_rstn;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] mbuf;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    misr_bist_ctrl dut (
        .clk_i           (clk),
        .rstn_i          (rstn),
        .start_i         (start),
        .num_patterns_i  (num),
        .golden_sig_i    (golden),
        .misr_sig_i      (misr_sig),
        .pattern_o       (pattern),
        .pattern_valid_o (valid),
        .misr_rstn_o     (misr_rstn),
        .busy_o          (busy),
        .done_o          (done),
        .pass_o          (pass)
    );

    // MISR: sig <= shift(sig, x^4+x^3+1) ^ buffered input; reset value 4'hF.
    always_ff @(posedge clk or negedge misr_rstn) begin
        if (!misr_rstn) begin
            misr_sig <= 4'hF;
            mbuf     <= 4'h0;
        end else begin
            mbuf     <= valid ? pattern : 4'h0;
            misr_sig <= {misr_sig[2:0], misr_sig[3] ^ misr_sig[2]} ^ mbuf;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full run from IDLE/DONE; poke >= 0 pulses start at that cycle index mid-run.
    task automatic run(input logic [7:0] n, input logic [3:0] g, input int exp_pass,
                       input int poke);
        int         cyc;
        int         nvalid;
        logic [3:0] lf;
        lf     = 4'b1001;
        nvalid = 0;
        cyc    = 0;
        @(negedge clk);
        num    = n;
        golden = g;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        num   = ~n;
        chk("clear_misr_rstn", 32'(misr_rstn), 32'd0);
        chk("clear_busy", 32'(busy), 32'd1);
        chk("clear_done", 32'(done), 32'd0);
        chk("clear_pass", 32'(pass), 32'd0);
        chk("clear_valid", 32'(valid), 32'd0);
        while (!done && cyc < 400) begin
            start = (cyc == poke);
            if (cyc == 1) chk("misr_rstn_rise", 32'(misr_rstn), 32'd1);
            if (valid) begin
                chk("pattern", 32'(pattern), 32'(lf));
                lf = {lf[2:0], lf[3] ^ lf[2]};
                nvalid++;
            end else begin
                chk("idle_pattern", 32'(pattern), 32'd0);
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk("latency", 32'(cyc), (n == 8'd0) ? 32'd2 : 32'(n) + 32'd4);
        chk("nvalid", 32'(nvalid), 32'(n));
        chk("done", 32'(done), 32'd1);
        chk("busy_in_done", 32'(busy), 32'd0);
        if (exp_pass >= 0) chk("pass", 32'(pass), 32'(exp_pass));
    endtask

    initial begin
        rstn   = 1'b0;
        start  = 1'b0;
        num    = 8'd0;
        golden = 4'h0;
        repeat (2) @(negedge clk);
        chk("rst_pattern", 32'(pattern), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_misr_rstn", 32'(misr_rstn), 32'd0);
        chk("rst_busy_done_pass", 32'({busy, done, pass}), 32'd0);

        // 1. Quiet after reset release.
        rstn = 1'b1;
        @(negedge clk);
        chk("misr_rstn_after_rst", 32'(misr_rstn), 32'd1);
        repeat (5) begin
            @(negedge clk);
            chk("quiet", 32'({busy, done, pass, valid, pattern}), 32'd0);
        end

        // 2./3. Four patterns, matching then mismatching golden.
        run(8'd4, 4'h4, 1, -1);
        run(8'd4, 4'h5, 0, -1);

        // 4. Zero patterns: MISR still holds 4'hF.
        run(8'd0, 4'hF, 1, -1);
        run(8'd0, 4'h0, 0, -1);

        // 5. start during RUN is ignored.
        run(8'd4, 4'h4, 1, 2);

        // Counter does not wrap at full scale.
        run(8'd255, 4'h0, -1, -1);

        // 6. Reset mid-RUN.
        @(negedge clk);
        num    = 8'd4;
        golden = 4'h4;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("midrun_valid", 32'(valid), 32'd1);
        #2 rstn = 1'b0;
        #1;
        chk("async_pattern", 32'(pattern), 32'd0);
        chk("async_valid", 32'(valid), 32'd0);
        chk("async_misr_rstn", 32'(misr_rstn), 32'd0);
        chk("async_busy_done_pass", 32'({busy, done, pass}), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("misr_rstn_after_rst2", 32'(misr_rstn), 32'd1);
        chk("idle_after_rst2", 32'({busy, done, pass}), 32'd0);
        run(8'd4, 4'h4, 1, -1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
